// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-map stage.
// Imported by the pointer sub-module and the register bank top.
package i2c_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] INVALID_RD = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    GET_PTR,
    WRITE_DATA
  } regbank_state_t;

endpackage

// File: rtl/i2c_reg_bank_reg_ptr.sv
// Register pointer: load, auto-advance with wrap at the top of the map.
// An out-of-range pointer is sticky: advance requests leave it unchanged.
module reg_ptr
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] load_val_i,
  input  logic              adv_i,
  output logic [BYTE_W-1:0] ptr_o,
  output logic              valid_o,
  output logic              moved_o
);

  localparam logic [BYTE_W:0] NREG =
    (BYTE_W+1)'(NUM_REGS);
  localparam logic [BYTE_W-1:0] LAST =
    BYTE_W'(NUM_REGS - 1);

  logic [BYTE_W-1:0] ptr_q, ptr_d;

  assign valid_o = {1'b0, ptr_q} < NREG;
  assign moved_o = load_i | (adv_i & valid_o);
  assign ptr_o   = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (adv_i && valid_o) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register-map stage behind the I2C slave: pointer byte, auto-increment
// writes and reads, read-only status registers fed from the fabric.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*BYTE_W-1:0] RESET_VAL = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       txn_start,
  input  logic                       txn_stop,
  input  logic [BYTE_W-1:0]          rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_req,
  output logic [BYTE_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       hw_we,
  input  logic [BYTE_W-1:0]          hw_addr,
  input  logic [BYTE_W-1:0]          hw_wdata,
  output logic [NUM_REGS*BYTE_W-1:0] regs_out,
  output logic                       wr_pulse,
  output logic [BYTE_W-1:0]          wr_addr,
  output logic                       err
);

  localparam int AW =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [BYTE_W:0] NREG =
    (BYTE_W+1)'(NUM_REGS);

  regbank_state_t state_q, state_d;

  logic [NUM_REGS-1:0][BYTE_W-1:0] regs_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              wr_pulse_q, wr_pulse_d;
  logic [BYTE_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;

  logic [BYTE_W-1:0] ptr;
  logic [AW-1:0]     idx, hw_idx;
  logic              ptr_ok, moved;
  logic              ld, adv, we;
  logic              ro_cur, hw_ok;
  logic              rx_go, tx_go;

  reg_ptr #(
    .NUM_REGS(NUM_REGS)
  ) u_ptr (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (ld),
    .load_val_i(rx_data),
    .adv_i     (adv),
    .ptr_o     (ptr),
    .valid_o   (ptr_ok),
    .moved_o   (moved)
  );

  assign idx    = ptr[AW-1:0];
  assign hw_idx = hw_addr[AW-1:0];
  assign ro_cur = ptr_ok & RO_MASK[idx];
  assign hw_ok  = hw_we
                & ({1'b0, hw_addr} < NREG)
                & RO_MASK[hw_idx];

  // Framing pulses own the cycle; a byte arriving with them is dropped.
  assign rx_go = rx_valid & ~txn_start & ~txn_stop;
  assign tx_go = tx_req & ~rx_valid;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    ld         = 1'b0;
    adv        = 1'b0;
    we         = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    if (rx_valid && tx_req) err_d = 1'b1;
    if (tx_go) begin
      if (ptr_ok) adv = 1'b1;
      else err_d = 1'b1;
    end
    if (rx_go) begin
      unique case (state_q)
        IDLE: err_d = 1'b1;
        GET_PTR: begin
          ld      = 1'b1;
          state_d = WRITE_DATA;
          if ({1'b0, rx_data} >= NREG) err_d = 1'b1;
        end
        WRITE_DATA: begin
          unique case (1'b1)
            !ptr_ok: err_d = 1'b1;
            ro_cur: begin
              err_d = 1'b1;
              adv   = 1'b1;
            end
            default: begin
              we         = 1'b1;
              adv        = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
    if (txn_stop) state_d = IDLE;
    if (txn_start) begin
      state_d = GET_PTR;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      regs_q     <= RESET_VAL;
      tx_data_q  <= RESET_VAL[BYTE_W-1:0];
      tx_valid_q <= 1'b1;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
      tx_data_q  <= ptr_ok ? regs_q[idx] : INVALID_RD;
      tx_valid_q <= ~moved;
      if (we) regs_q[idx] <= rx_data;
      if (hw_ok) regs_q[hw_idx] <= hw_wdata;
    end
  end

  assign regs_out = regs_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomized and directed bench for i2c_reg_bank against a
// transaction-level reference model of the register map.
module tb_i2c_reg_bank;

  localparam int N = 16;
  localparam logic [N-1:0] RO = 16'h0104;
  localparam logic [N*8-1:0] RV =
    128'hFF_EE_DD_CC_BB_AA_99_88_77_66_55_44_33_22_11_A5;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           txn_start = 1'b0;
  logic           txn_stop = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           tx_req = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           hw_we = 1'b0;
  logic [7:0]     hw_addr = '0;
  logic [7:0]     hw_wdata = '0;
  logic [N*8-1:0] regs_out;
  logic           wr_pulse;
  logic [7:0]     wr_addr;
  logic           err;

  always #5 clock = ~clock;

  i2c_reg_bank #(
    .NUM_REGS (N),
    .RO_MASK  (RO),
    .RESET_VAL(RV)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .txn_start(txn_start),
    .txn_stop (txn_stop),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .hw_we    (hw_we),
    .hw_addr  (hw_addr),
    .hw_wdata (hw_wdata),
    .regs_out (regs_out),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .err      (err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Reference model: register contents, pointer as an integer,
  // and whether a transaction is open / still waiting for its pointer.
  logic [7:0] m_reg[N];
  int         m_ptr;
  bit         m_err, m_open, m_need_ptr;
  logic [7:0] m_tx, m_wa;
  bit         m_txv, m_wp;
  int         cyc_n = 0;
  int         last_tx = -100;

  function automatic int next_ptr(input int p);
    return (p == N - 1) ? 0 : p + 1;
  endfunction

  function automatic logic [N*8-1:0] image();
    logic [N*8-1:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = m_reg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = RV[i*8 +: 8];
    m_ptr = 0;
    m_err = 0;
    m_open = 0;
    m_need_ptr = 0;
    m_tx = RV[7:0];
    m_txv = 1;
    m_wp = 0;
    m_wa = 8'h00;
  endtask

  task automatic model_step(input bit st, input bit sp,
                            input bit rx, input logic [7:0] d,
                            input bit tx, input bit hwe,
                            input logic [7:0] ha,
                            input logic [7:0] hd);
    bit moved = 0;
    m_tx = (m_ptr < N) ? m_reg[m_ptr] : 8'hFF;
    m_wp = 0;
    if (rx && tx) m_err = 1;
    if (tx && !rx) begin
      if (m_ptr < N) begin
        m_ptr = next_ptr(m_ptr);
        moved = 1;
      end else m_err = 1;
    end
    if (rx && !st && !sp) begin
      if (!m_open) m_err = 1;
      else if (m_need_ptr) begin
        m_ptr = int'(d);
        m_need_ptr = 0;
        moved = 1;
        if (m_ptr >= N) m_err = 1;
      end else if (m_ptr >= N) m_err = 1;
      else if (RO[m_ptr]) begin
        m_err = 1;
        m_ptr = next_ptr(m_ptr);
        moved = 1;
      end else begin
        m_reg[m_ptr] = d;
        m_wp = 1;
        m_wa = 8'(m_ptr);
        m_ptr = next_ptr(m_ptr);
        moved = 1;
      end
    end
    if (hwe && int'(ha) < N && RO[ha[3:0]]) m_reg[ha[3:0]] = hd;
    if (sp) m_open = 0;
    if (st) begin
      m_open = 1;
      m_need_ptr = 1;
      m_err = 0;
    end
    m_txv = !moved;
  endtask

  task automatic check_all(input string p);
    check({p, ".regs"}, 128'(regs_out), 128'(image()));
    check({p, ".tx_data"}, 128'(tx_data), 128'(m_tx));
    check({p, ".tx_valid"}, 128'(tx_valid), 128'(m_txv));
    check({p, ".wr_pulse"}, 128'(wr_pulse), 128'(m_wp));
    check({p, ".wr_addr"}, 128'(wr_addr), 128'(m_wa));
    check({p, ".err"}, 128'(err), 128'(m_err));
  endtask

  task automatic cyc(input string p,
                     input bit st, input bit sp,
                     input bit rx, input logic [7:0] d,
                     input bit tx, input bit hwe,
                     input logic [7:0] ha,
                     input logic [7:0] hd);
    txn_start = st;
    txn_stop = sp;
    rx_valid = rx;
    rx_data = d;
    tx_req = tx;
    hw_we = hwe;
    hw_addr = ha;
    hw_wdata = hd;
    @(posedge clock);
    model_step(st, sp, rx, d, tx, hwe, ha, hd);
    cyc_n++;
    if (tx) last_tx = cyc_n;
    #1;
    txn_start = 0;
    txn_stop = 0;
    rx_valid = 0;
    tx_req = 0;
    hw_we = 0;
    check_all(p);
  endtask

  task automatic idle(input string p);
    cyc(p, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask
  task automatic start(input string p);
    cyc(p, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask
  task automatic stop(input string p);
    cyc(p, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask
  task automatic rxb(input string p, input logic [7:0] d);
    cyc(p, 0, 0, 1, d, 0, 0, 8'h00, 8'h00);
  endtask
  task automatic txr(input string p);
    cyc(p, 0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00);
  endtask
  task automatic hww(input string p,
                     input logic [7:0] a,
                     input logic [7:0] d);
    cyc(p, 0, 0, 0, 8'h00, 0, 1, a, d);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst.tx_data", 128'(tx_data), 128'(8'hA5));
    check("rst.tx_valid", 128'(tx_valid), 128'(1'b1));
    check("rst.regs", 128'(regs_out), 128'(RV));
    check("rst.err", 128'(err), 128'(1'b0));
    check("rst.wr_pulse", 128'(wr_pulse), 128'(1'b0));
    reset_n = 1;

    start("wb");
    rxb("wb.ptr", 8'h0E);
    rxb("wb.d0", 8'h11);
    check("wb.addr14", 128'(wr_addr), 128'(8'd14));
    rxb("wb.d1", 8'h22);
    check("wb.addr15", 128'(wr_addr), 128'(8'd15));
    rxb("wb.d2", 8'h33);
    check("wb.addr0", 128'(wr_addr), 128'(8'd0));
    check("wb.pulse", 128'(wr_pulse), 128'(1'b1));
    check("wb.reg14", 128'(regs_out[14*8 +: 8]), 128'(8'h11));
    check("wb.reg15", 128'(regs_out[15*8 +: 8]), 128'(8'h22));
    check("wb.reg0", 128'(regs_out[0 +: 8]), 128'(8'h33));
    stop("wb.stop");

    start("rd");
    rxb("rd.ptr", 8'h03);
    check("rd.ldlow", 128'(tx_valid), 128'(1'b0));
    start("rd.rs");
    check("rd.reg3", 128'(tx_data), 128'(8'h33));
    txr("rd.tx0");
    check("rd.advlow", 128'(tx_valid), 128'(1'b0));
    idle("rd.i0");
    check("rd.reg4", 128'(tx_data), 128'(8'h44));
    idle("rd.i1");
    txr("rd.tx1");
    idle("rd.i2");
    check("rd.reg5", 128'(tx_data), 128'(8'h55));
    stop("rd.stop");

    start("ro");
    rxb("ro.ptr", 8'h02);
    rxb("ro.wr", 8'h99);
    check("ro.keep", 128'(regs_out[2*8 +: 8]), 128'(8'h22));
    check("ro.err", 128'(err), 128'(1'b1));
    check("ro.nopulse", 128'(wr_pulse), 128'(1'b0));
    hww("ro.hw2", 8'd2, 8'h5A);
    check("ro.hwreg2", 128'(regs_out[2*8 +: 8]), 128'(8'h5A));
    hww("ro.hw4", 8'd4, 8'h00);
    check("ro.hwrw", 128'(regs_out[4*8 +: 8]), 128'(8'h44));
    stop("ro.stop");

    start("inv");
    rxb("inv.ptr", 8'h20);
    idle("inv.i0");
    check("inv.ff", 128'(tx_data), 128'(8'hFF));
    rxb("inv.wr", 8'h12);
    idle("inv.i1");
    txr("inv.tx");
    idle("inv.i2");
    check("inv.stay", 128'(tx_data), 128'(8'hFF));
    check("inv.err", 128'(err), 128'(1'b1));
    start("inv.clr");
    check("inv.errclr", 128'(err), 128'(1'b0));
    stop("inv.stop");

    start("cf");
    rxb("cf.ptr", 8'h06);
    cyc("cf.both", 0, 0, 1, 8'h6B, 1, 0, 8'h00, 8'h00);
    check("cf.reg6", 128'(regs_out[6*8 +: 8]), 128'(8'h6B));
    check("cf.err", 128'(err), 128'(1'b1));
    rxb("cf.next", 8'h7C);
    check("cf.addr7", 128'(wr_addr), 128'(8'd7));
    check("cf.reg7", 128'(regs_out[7*8 +: 8]), 128'(8'h7C));
    stop("cf.stop");

    for (int i = 0; i < 600; i++) begin
      bit st, sp, rx, tx, hwe;
      logic [7:0] d, ha, hd;
      st = $urandom_range(0, 99) < 6;
      sp = $urandom_range(0, 99) < 3;
      rx = $urandom_range(0, 99) < 35;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                      : 8'($urandom_range(0, 17));
      tx = ($urandom_range(0, 99) < 20) && (cyc_n - last_tx >= 2);
      hwe = $urandom_range(0, 99) < 15;
      ha = 8'($urandom_range(0, 20));
      hd = 8'($urandom);
      cyc("rnd", st, sp, rx, d, tx, hwe, ha, hd);
    end

    start("mr");
    rxb("mr.ptr", 8'h09);
    rxb("mr.d0", 8'hC3);
    reset_n = 0;
    #1;
    model_reset();
    check("mr.tx_data", 128'(tx_data), 128'(8'hA5));
    check("mr.tx_valid", 128'(tx_valid), 128'(1'b1));
    check("mr.regs", 128'(regs_out), 128'(RV));
    check("mr.wr_addr", 128'(wr_addr), 128'(8'h00));
    check("mr.err", 128'(err), 128'(1'b0));
    #2;
    reset_n = 1;
    rxb("mr.idle_rx", 8'h01);
    idle("mr.i0");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
